// File: rtl/spi_burst_scheduler.sv
// Sampling sequencer that owns the register bus of one spi_master_burst: sweeps channels on
// period ticks or triggers, loads commands, polls Busy and drains each reply into a result bank.
module spi_burst_scheduler #(
  parameter int unsigned BaseAddress         = 0,
  parameter int unsigned MasterBase          = 16,
  parameter int unsigned BytesPerTransaction = 2,
  parameter int unsigned MaxChannels         = 8,
  parameter int unsigned CmdBase             = 'h80,
  parameter int unsigned address_width       = 16,
  parameter int unsigned data_width          = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [address_width-1:0] address_i,
  input  logic [data_width-1:0]    data_i,
  output logic [data_width-1:0]    data_o,
  input  logic                     rd_wr_i,
  output logic [address_width-1:0] m_address_o,
  output logic [data_width-1:0]    m_data_o,
  output logic                     m_rd_wr_o,
  input  logic [data_width-1:0]    m_data_i
);
  localparam int unsigned AW       = address_width;
  localparam int unsigned DW       = data_width;
  localparam int unsigned BPT      = BytesPerTransaction;
  localparam int unsigned NRES     = MaxChannels * BPT;
  localparam int unsigned OWN_SPAN = 8 + NRES;
  localparam int unsigned CW       = $clog2(MaxChannels + 1);
  localparam int unsigned KW       = (BPT > 1) ? $clog2(BPT) : 1;
  localparam int unsigned RW       = (NRES > 1) ? $clog2(NRES) : 1;

  localparam logic [AW-1:0] BASE    = AW'(BaseAddress);
  localparam logic [AW-1:0] M_WRITE = AW'(MasterBase);
  localparam logic [AW-1:0] M_READ  = AW'(MasterBase + 1);
  localparam logic [AW-1:0] M_START = AW'(MasterBase + 2);
  localparam logic [AW-1:0] M_BUSY  = AW'(MasterBase + 3);
  localparam logic [AW-1:0] M_PARK  = AW'(MasterBase + 5);
  localparam logic [DW-1:0] MAXC_D  = DW'(MaxChannels);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_START, S_SETTLE, S_POLL_REQ, S_POLL_CHK, S_READ_REQ, S_READ_CAP, S_NEXT
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   chan_q, chan_d, sweep_cnt_q, sweep_cnt_d, chan_count_q;
  logic [KW-1:0]   k_q, k_d;
  logic [1:0]      settle_q, settle_d;
  logic            enable_q, trigger_q, overrun_q, pass_rd_q;
  logic [15:0]     period_q, tick_cnt_q;
  logic [DW-1:0]   data_q;
  logic [DW-1:0]   results_q [NRES];

  logic [AW-1:0]   own_off, m_off;
  logic            own_hit, mst_hit, tick, start, pass, cap_en, cpu_wr_own;
  logic [RW-1:0]   res_cpu_idx, cap_idx;
  logic [DW-1:0]   rd_val, cc_wr;

  // Offsets wrap for addresses below a window base, so one unsigned compare decodes each window.
  // The master window wins where the two windows overlap.
  always_comb begin
    own_off     = address_i - BASE;
    m_off       = address_i - M_WRITE;
    mst_hit     = m_off < AW'(5);
    own_hit     = (own_off < AW'(OWN_SPAN)) && !mst_hit;
    cpu_wr_own  = rd_wr_i && own_hit;
    res_cpu_idx = RW'(own_off - AW'(8));
    cap_idx     = RW'(chan_q * BPT + k_q);
    tick        = enable_q && (tick_cnt_q == period_q);
    start       = tick || trigger_q;
    pass        = (state_q == S_IDLE) && !start && mst_hit && !reset_i;
    rd_val      = '0;
    case (own_off)
      AW'(0):  rd_val = DW'(enable_q);
      AW'(1):  rd_val = DW'({overrun_q, state_q != S_IDLE});
      AW'(2):  rd_val = DW'(period_q[7:0]);
      AW'(3):  rd_val = DW'(period_q[15:8]);
      AW'(4):  rd_val = DW'(chan_count_q);
      default: if (own_off >= AW'(8)) rd_val = results_q[res_cpu_idx];
    endcase
    if (data_i == '0)        cc_wr = DW'(1);
    else if (data_i > MAXC_D) cc_wr = MAXC_D;
    else                      cc_wr = data_i;
  end

  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    k_d         = k_q;
    settle_d    = settle_q;
    sweep_cnt_d = sweep_cnt_q;
    m_address_o = M_PARK;
    m_data_o    = '0;
    m_rd_wr_o   = 1'b0;
    cap_en      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_LOAD;
          chan_d      = '0;
          k_d         = '0;
          sweep_cnt_d = chan_count_q;
        end else if (pass) begin
          m_address_o = address_i;
          m_data_o    = data_i;
          m_rd_wr_o   = rd_wr_i;
        end
      end
      S_LOAD: begin
        m_address_o = M_WRITE;
        m_rd_wr_o   = 1'b1;
        m_data_o    = (k_q == '0) ? (DW'(CmdBase) | DW'(chan_q)) : '0;
        if (k_q == KW'(BPT - 1)) begin
          k_d     = '0;
          state_d = S_START;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_START: begin
        m_address_o = M_START;
        m_rd_wr_o   = 1'b1;
        m_data_o    = DW'(1);
        settle_d    = '0;
        state_d     = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == 2'd3) state_d = S_POLL_REQ;
        else                  settle_d = settle_q + 1'b1;
      end
      S_POLL_REQ: begin
        m_address_o = M_BUSY;
        state_d     = S_POLL_CHK;
      end
      S_POLL_CHK: begin
        if (m_data_i[0]) begin
          state_d = S_POLL_REQ;
        end else begin
          k_d     = '0;
          state_d = S_READ_REQ;
        end
      end
      S_READ_REQ: begin
        m_address_o = M_READ;
        state_d     = S_READ_CAP;
      end
      S_READ_CAP: begin
        cap_en = 1'b1;
        if (k_q == KW'(BPT - 1)) begin
          state_d = S_NEXT;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = S_READ_REQ;
        end
      end
      S_NEXT: begin
        if (chan_q + 1'b1 < sweep_cnt_q) begin
          chan_d  = chan_q + 1'b1;
          k_d     = '0;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      chan_q       <= '0;
      k_q          <= '0;
      settle_q     <= '0;
      sweep_cnt_q  <= '0;
      enable_q     <= 1'b0;
      trigger_q    <= 1'b0;
      overrun_q    <= 1'b0;
      period_q     <= '1;
      chan_count_q <= CW'(1);
      tick_cnt_q   <= '0;
      data_q       <= '0;
      pass_rd_q    <= 1'b0;
      for (int unsigned i = 0; i < NRES; i++) results_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      k_q         <= k_d;
      settle_q    <= settle_d;
      sweep_cnt_q <= sweep_cnt_d;
      trigger_q   <= cpu_wr_own && (own_off == AW'(0)) && data_i[1];
      if (!enable_q || tick) tick_cnt_q <= '0;
      else                   tick_cnt_q <= tick_cnt_q + 1'b1;
      if (start && state_q != S_IDLE)             overrun_q <= 1'b1;
      else if (cpu_wr_own && own_off == AW'(1))   overrun_q <= 1'b0;
      if (cpu_wr_own && own_off == AW'(0)) enable_q <= data_i[0];
      if (cpu_wr_own && own_off == AW'(2)) period_q[7:0] <= data_i[7:0];
      if (cpu_wr_own && own_off == AW'(3)) period_q[15:8] <= data_i[7:0];
      if (cpu_wr_own && own_off == AW'(4)) chan_count_q <= CW'(cc_wr);
      if (cap_en) results_q[cap_idx] <= m_data_i;
      data_q    <= (!rd_wr_i && own_hit) ? rd_val : '0;
      pass_rd_q <= pass && !rd_wr_i;
    end
  end

  // Master read data is already registered, so a forwarded read shows it one cycle later.
  assign data_o = pass_rd_q ? m_data_i : data_q;

endmodule

// File: tb/tb_spi_burst_scheduler.sv
// Directed bench for spi_burst_scheduler with a behavioural spi_master_burst register model.
module tb_spi_burst_scheduler;
  localparam logic [15:0] CTRL = 16'd32, STATUS = 16'd33, PLO = 16'd34, PHI = 16'd35;
  localparam logic [15:0] CC = 16'd36, RES = 16'd40, PARK = 16'd100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] address_i = PARK;
  logic [7:0]  data_i = '0;
  logic        rd_wr_i = 1'b0;
  logic [7:0]  data_o;
  logic [15:0] m_address_o;
  logic [7:0]  m_data_o;
  logic        m_rd_wr_o;
  logic [7:0]  m_data_i;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0] tx_log[$];
  logic [7:0] txcur[$];
  logic [7:0] rxq[$];
  int         start_cycles[$];
  int         starts = 0;
  int         busy_cnt = 0;
  int         busy_len = 10;
  logic [7:0] resp_hi = 8'hA5;
  logic [7:0] bfm_tmp;

  spi_burst_scheduler #(
    .BaseAddress(32),
    .MasterBase(16),
    .BytesPerTransaction(2),
    .MaxChannels(8),
    .CmdBase('h80),
    .address_width(16),
    .data_width(8)
  ) dut (
    .clk_i(clk),
    .reset_i(rst),
    .address_i(address_i),
    .data_i(data_i),
    .data_o(data_o),
    .rd_wr_i(rd_wr_i),
    .m_address_o(m_address_o),
    .m_data_o(m_data_o),
    .m_rd_wr_o(m_rd_wr_o),
    .m_data_i(m_data_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Master model: replies 16'hA5Cn (high byte set by resp_hi) for channel n, Busy for busy_len cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt = 0;
      rxq.delete();
      txcur.delete();
      m_data_i <= 8'h00;
    end else begin
      m_data_i <= 8'h00;
      if (busy_cnt > 0) busy_cnt--;
      if (m_rd_wr_o) begin
        if (m_address_o == 16'd16) begin
          tx_log.push_back(m_data_o);
          txcur.push_back(m_data_o);
        end else if (m_address_o == 16'd18) begin
          bfm_tmp = (txcur.size() > 0) ? txcur[0] : 8'h00;
          rxq.delete();
          rxq.push_back(resp_hi);
          rxq.push_back(8'hC0 | {4'h0, bfm_tmp[3:0]});
          txcur.delete();
          busy_cnt = busy_len;
          starts++;
          if (bfm_tmp[3:0] == 4'h0) start_cycles.push_back(cyc);
        end
      end else begin
        case (m_address_o)
          16'd17: if (rxq.size() > 0) m_data_i <= rxq.pop_front();
          16'd19: m_data_i <= (busy_cnt > 0) ? 8'h01 : 8'h00;
          16'd20: m_data_i <= 8'h37;
          default: m_data_i <= 8'h00;
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    address_i = a; data_i = d; rd_wr_i = 1'b1;
    @(posedge clk); #1;
    address_i = PARK; data_i = '0; rd_wr_i = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
    @(posedge clk); #1;
    address_i = a; rd_wr_i = 1'b0;
    @(posedge clk); #1;
    d = data_o;
    address_i = PARK;
  endtask

  task automatic wait_idle(input int max_polls);
    logic [7:0] s;
    s = 8'h01;
    for (int i = 0; i < max_polls; i++) begin
      cpu_read(STATUS, s);
      if (s[0] == 1'b0) break;
    end
    check("idle", {31'd0, s[0]}, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] v;
    logic [7:0] exp_cmd [6];
    logic [7:0] exp_res [6];
    int s0, found, n77;
    exp_cmd = '{8'h80, 8'h00, 8'h81, 8'h00, 8'h82, 8'h00};
    exp_res = '{8'hA5, 8'hC0, 8'hA5, 8'hC1, 8'hA5, 8'hC2};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_m_addr", m_address_o, 16'd21);
    check("rst_m_rdwr", m_rd_wr_o, 0);
    check("rst_m_data", m_data_o, 0);
    check("rst_data_o", data_o, 0);
    cpu_read(CTRL, v);   check("rst_ctrl", v, 8'h00);
    cpu_read(STATUS, v); check("rst_status", v, 8'h00);
    cpu_read(PLO, v);    check("rst_plo", v, 8'hFF);
    cpu_read(PHI, v);    check("rst_phi", v, 8'hFF);
    cpu_read(CC, v);     check("rst_cc", v, 8'h01);
    cpu_read(RES, v);    check("rst_res0", v, 8'h00);

    // Passthrough while idle
    @(posedge clk); #1;
    address_i = 16'd16; data_i = 8'h5A; rd_wr_i = 1'b1;
    #1;
    check("pt_addr", m_address_o, 16'd16);
    check("pt_data", m_data_o, 8'h5A);
    check("pt_rdwr", m_rd_wr_o, 1);
    @(posedge clk); #1;
    address_i = PARK; data_i = '0; rd_wr_i = 1'b0;
    cpu_read(16'd20, v); check("pt_rd_num", v, 8'h37);
    tx_log.delete();
    txcur.delete();

    // Periodic sweeps: PERIOD=99, 3 channels
    cpu_write(PLO, 8'd99);
    cpu_write(PHI, 8'd0);
    cpu_write(CC, 8'd3);
    cpu_write(CTRL, 8'h01);
    for (int i = 0; i < 400 && start_cycles.size() < 2; i++) @(posedge clk);
    check("tick_seen", start_cycles.size() >= 2, 1);
    if (start_cycles.size() >= 2) check("tick_gap", start_cycles[1] - start_cycles[0], 100);
    cpu_write(CTRL, 8'h00);
    wait_idle(100);
    check("cmd_count", tx_log.size() >= 6, 1);
    if (tx_log.size() >= 6)
      for (int i = 0; i < 6; i++) check($sformatf("cmd%0d", i), tx_log[i], exp_cmd[i]);
    for (int i = 0; i < 6; i++) begin
      cpu_read(RES + 16'(i), v);
      check($sformatf("res%0d", i), v, exp_res[i]);
    end

    // One-shot trigger with enable=0, blocked CPU access mid-sweep
    busy_len = 30;
    s0 = starts;
    tx_log.delete();
    cpu_write(CTRL, 8'h02);
    repeat (8) @(posedge clk);
    @(posedge clk); #1;
    address_i = 16'd16; data_i = 8'h77; rd_wr_i = 1'b1;
    #1;
    check("mid_wr_data", m_data_o, 8'h00);
    check("mid_wr_rdwr", m_rd_wr_o, 0);
    @(posedge clk); #1;
    address_i = PARK; data_i = '0; rd_wr_i = 1'b0;
    cpu_read(16'd19, v);   check("mid_rd_busy", v, 8'h00);
    cpu_read(STATUS, v);   check("trig_active", v, 8'h01);
    wait_idle(150);
    check("trig_starts", starts - s0, 3);
    n77 = 0;
    foreach (tx_log[i]) if (tx_log[i] == 8'h77) n77++;
    check("mid_wr_dropped", n77, 0);
    repeat (150) @(posedge clk);
    check("trig_no_more", starts - s0, 3);

    // Overrun: period 11 cycles against a ~50-cycle sweep
    resp_hi = 8'h3C;
    busy_len = 40;
    cpu_write(CC, 8'd1);
    cpu_write(PLO, 8'd10);
    cpu_write(PHI, 8'd0);
    cpu_write(CTRL, 8'h01);
    repeat (80) @(posedge clk);
    cpu_read(STATUS, v);   check("ovr_set", v[1], 1);
    cpu_write(CTRL, 8'h00);
    wait_idle(100);
    cpu_write(STATUS, 8'h00);
    cpu_read(STATUS, v);   check("ovr_clear", v, 8'h00);
    cpu_read(RES, v);      check("ovr_res0", v, 8'h3C);
    cpu_read(RES + 16'd1, v); check("ovr_res1", v, 8'hC0);

    // CHAN_COUNT clamping and a full 8-channel sweep
    resp_hi = 8'hA5;
    busy_len = 2;
    cpu_write(CC, 8'd0);   cpu_read(CC, v); check("cc_zero", v, 8'd1);
    cpu_write(CC, 8'd20);  cpu_read(CC, v); check("cc_clamp", v, 8'd8);
    s0 = starts;
    tx_log.delete();
    cpu_write(CTRL, 8'h02);
    wait_idle(300);
    check("cc8_starts", starts - s0, 8);
    if (tx_log.size() >= 2) check("cc8_last_cmd", tx_log[tx_log.size() - 2], 8'h87);
    cpu_read(RES + 16'd14, v); check("cc8_res14", v, 8'hA5);
    cpu_read(RES + 16'd15, v); check("cc8_res15", v, 8'hC7);

    // Reset asserted while in POLL_CHK
    busy_len = 30;
    cpu_write(CTRL, 8'h02);
    @(posedge clk); #1;
    address_i = CC; rd_wr_i = 1'b0;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (m_address_o == 16'd19) begin found = 1; break; end
    end
    check("poll_seen", found, 1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("mrst_m_addr", m_address_o, 16'd21);
    check("mrst_m_rdwr", m_rd_wr_o, 0);
    check("mrst_m_data", m_data_o, 0);
    check("mrst_data_o", data_o, 0);
    address_i = PARK;
    @(posedge clk); #3;
    rst = 1'b0;
    cpu_read(STATUS, v);  check("mrst_status", v, 8'h00);
    cpu_read(CC, v);      check("mrst_cc", v, 8'h01);
    cpu_read(PHI, v);     check("mrst_phi", v, 8'hFF);
    cpu_read(RES + 16'd2, v); check("mrst_res2", v, 8'h00);
    busy_len = 5;
    cpu_write(CTRL, 8'h02);
    wait_idle(100);
    cpu_read(RES, v);         check("post_res0", v, 8'hA5);
    cpu_read(RES + 16'd1, v); check("post_res1", v, 8'hC0);
    cpu_read(RES + 16'd2, v); check("post_res2", v, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
